// File: rtl/mips8_cpu_core.sv
// mips8_cpu_core: multicycle MIPS-style CPU with 32-bit instructions and an 8-bit datapath.
// A FETCH/DECODE/EXEC/MEM sequencer drives two synchronous RAMs through Moore-decoded strobes.
module mips8_cpu_core #(
  parameter int RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rden,
  output logic [7:0]  address,
  input  logic [31:0] command,
  output logic        rden_dm,
  output logic [7:0]  rdaddress_dm,
  input  logic [7:0]  read_data_dm,
  output logic        wren_dm,
  output logic [7:0]  wraddress_dm,
  output logic [7:0]  write_data_dm
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM} state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  rf_q [RF_DEPTH];
  logic [7:0]  rf_d [RF_DEPTH];

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [7:0]  imm8;
  logic [7:0]  ea;
  logic [8:0]  alu_out;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [7:0]  wr_val;
  logic        unused_ir;

  function automatic logic slt8(input logic [7:0] x, input logic [7:0] y);
    logic signed [7:0] sx;
    logic signed [7:0] sy;
    sx = signed'(x);
    sy = signed'(y);
    return (sx < sy);
  endfunction

  // Returns {valid, result}; valid=0 marks an unsupported funct (treated as NOP).
  function automatic logic [8:0] alu_r(input logic [5:0] fn, input logic [7:0] x,
                                       input logic [7:0] y);
    case (fn)
      FN_ADD:  return {1'b1, 8'(x + y)};
      FN_SUB:  return {1'b1, 8'(x - y)};
      FN_AND:  return {1'b1, x & y};
      FN_OR:   return {1'b1, x | y};
      FN_SLT:  return {1'b1, 7'd0, slt8(x, y)};
      default: return 9'd0;
    endcase
  endfunction

  assign op      = ir_q[31:26];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign funct   = ir_q[5:0];
  assign imm8    = ir_q[7:0];
  assign ea      = a_q + imm8;
  assign alu_out = alu_r(funct, a_q, b_q);

  // rs index is consumed in DECODE straight from command; shamt and imm[10:8] are unused.
  assign unused_ir = ^{ir_q[25:21], ir_q[10:8]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    rf_d    = rf_q;
    wr_en   = 1'b0;
    wr_idx  = 5'd0;
    wr_val  = 8'd0;

    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = command;
        a_d     = rf_q[command[25:21]];
        b_d     = rf_q[command[20:16]];
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_RTYPE: begin
            wr_en  = alu_out[8];
            wr_idx = rd;
            wr_val = alu_out[7:0];
          end
          OP_ADDI: begin
            wr_en  = 1'b1;
            wr_idx = rt;
            wr_val = ea;
          end
          OP_LW:   state_d = S_MEM;
          OP_BEQ:  if (a_q == b_q) pc_d = pc_q + imm8;
          OP_J:    pc_d = ir_q[7:0];
          default: ;
        endcase
      end
      S_MEM: begin
        wr_en   = 1'b1;
        wr_idx  = rt;
        wr_val  = read_data_dm;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // r0 is never written, so it stays at its reset value of zero.
    if (wr_en && (wr_idx != 5'd0)) rf_d[wr_idx] = wr_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Strobes are gated by reset so nothing fires while reset is held, even though state is FETCH.
  assign rden          = reset && (state_q == S_FETCH);
  assign address       = pc_q;
  assign rden_dm       = reset && (state_q == S_EXEC) && (op == OP_LW);
  assign rdaddress_dm  = rden_dm ? ea : 8'd0;
  assign wren_dm       = reset && (state_q == S_EXEC) && (op == OP_SW);
  assign wraddress_dm  = wren_dm ? ea : 8'd0;
  assign write_data_dm = wren_dm ? b_q : 8'd0;

endmodule

// File: tb/tb_mips8_cpu_core.sv
// Self-checking bench for mips8_cpu_core: table of small programs with expected
// store/fetch results, plus hand-written reset, lw-timing and abort sequences.
module tb_mips8_cpu_core;

  logic        clk;
  logic        reset;
  logic        rden;
  logic [7:0]  address;
  logic [31:0] command;
  logic        rden_dm;
  logic [7:0]  rdaddress_dm;
  logic [7:0]  read_data_dm;
  logic        wren_dm;
  logic [7:0]  wraddress_dm;
  logic [7:0]  write_data_dm;

  mips8_cpu_core #(.RF_DEPTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .rden         (rden),
    .address      (address),
    .command      (command),
    .rden_dm      (rden_dm),
    .rdaddress_dm (rdaddress_dm),
    .read_data_dm (read_data_dm),
    .wren_dm      (wren_dm),
    .wraddress_dm (wraddress_dm),
    .write_data_dm(write_data_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [7:0]  dmem [256];

  always @(posedge clk) begin
    if (rden)    command      <= imem[address];
    if (rden_dm) read_data_dm <= dmem[rdaddress_dm];
  end

  typedef struct {
    string            name;
    logic [5:0][31:0] prog;
    bit               is_fetch;
    int               nsw;
    logic [7:0]       exp_addr;
    logic [7:0]       exp_data;
    int               fidx;
  } vec_t;

  vec_t vecs[$];

  int         n_cmp;
  int         n_fail;
  logic [7:0] fetch_addr [64];
  int         fetch_cyc  [64];
  int         fetch_cnt;
  int         wr_cnt;
  int         rdm_cnt;
  int         rdm_cyc;
  int         ovl;
  logic [7:0] last_wa;
  logic [7:0] last_wd;
  logic [7:0] last_ra;

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                        input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  function automatic vec_t mkv(input string name, input logic [31:0] p0, input logic [31:0] p1,
                               input logic [31:0] p2, input logic [31:0] p3,
                               input logic [31:0] p4, input logic [31:0] p5, input bit isf,
                               input int nsw, input logic [7:0] ea, input logic [7:0] ed,
                               input int fidx);
    vec_t v;
    v.name     = name;
    v.prog[0]  = p0;
    v.prog[1]  = p1;
    v.prog[2]  = p2;
    v.prog[3]  = p3;
    v.prog[4]  = p4;
    v.prog[5]  = p5;
    v.is_fetch = isf;
    v.nsw      = nsw;
    v.exp_addr = ea;
    v.exp_data = ed;
    v.fidx     = fidx;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_prog(input logic [5:0][31:0] p);
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    for (int i = 0; i < 6; i++) imem[i] = p[i];
  endtask

  task automatic start(input logic [5:0][31:0] p);
    @(negedge clk);
    reset = 1'b0;
    load_prog(p);
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Cycle i (0 = first cycle after reset release) is sampled 1ns after its negedge.
  task automatic run_cycles(input int n);
    fetch_cnt = 0;
    wr_cnt    = 0;
    rdm_cnt   = 0;
    rdm_cyc   = -1;
    ovl       = 0;
    last_wa   = 8'h00;
    last_wd   = 8'h00;
    last_ra   = 8'h00;
    for (int i = 0; i < n; i++) begin
      #1;
      if (rden && fetch_cnt < 64) begin
        fetch_addr[fetch_cnt] = address;
        fetch_cyc[fetch_cnt]  = i;
        fetch_cnt++;
      end
      if (wren_dm) begin
        wr_cnt++;
        last_wa = wraddress_dm;
        last_wd = write_data_dm;
      end
      if (rden_dm) begin
        rdm_cnt++;
        rdm_cyc = i;
        last_ra = rdaddress_dm;
      end
      if (wren_dm && rden_dm) ovl++;
      @(negedge clk);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0;

  initial begin
    logic [5:0][31:0] p;
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'hA5;
    dmem[7] = 8'h3C;

    vecs.push_back(mkv("addi_add", i_ins(6'h08,0,1,16'd5), i_ins(6'h08,0,2,16'd250),
                       r_ins(1,2,3,6'h20), i_ins(6'h2B,0,3,16'd0), NOP, NOP, 0, 1, 8'h00, 8'hFF, 0));
    vecs.push_back(mkv("wrap", i_ins(6'h08,0,1,16'd200), i_ins(6'h08,1,2,16'd100),
                       i_ins(6'h2B,0,2,16'd1), NOP, NOP, NOP, 0, 1, 8'h01, 8'd44, 0));
    vecs.push_back(mkv("slt_neg", i_ins(6'h08,0,1,16'd200), r_ins(1,0,4,6'h2A),
                       i_ins(6'h2B,0,4,16'd2), NOP, NOP, NOP, 0, 1, 8'h02, 8'h01, 0));
    vecs.push_back(mkv("sub", i_ins(6'h08,0,1,16'd3), i_ins(6'h08,0,2,16'd5),
                       r_ins(1,2,3,6'h22), i_ins(6'h2B,0,3,16'd9), NOP, NOP, 0, 1, 8'h09, 8'hFE, 0));
    vecs.push_back(mkv("and", i_ins(6'h08,0,1,16'hCC), i_ins(6'h08,0,2,16'hAA),
                       r_ins(1,2,3,6'h24), i_ins(6'h2B,0,3,16'd4), NOP, NOP, 0, 1, 8'h04, 8'h88, 0));
    vecs.push_back(mkv("or", i_ins(6'h08,0,1,16'hCC), i_ins(6'h08,0,2,16'hAA),
                       r_ins(1,2,3,6'h25), i_ins(6'h2B,0,3,16'd4), NOP, NOP, 0, 1, 8'h04, 8'hEE, 0));
    vecs.push_back(mkv("slt_signed", i_ins(6'h08,0,1,16'd5), i_ins(6'h08,0,2,16'd200),
                       i_ins(6'h08,0,3,16'd7), r_ins(1,2,3,6'h2A), i_ins(6'h2B,0,3,16'd6), NOP,
                       0, 1, 8'h06, 8'h00, 0));
    vecs.push_back(mkv("lw_sw", i_ins(6'h23,0,5,16'd7), i_ins(6'h2B,0,5,16'd8),
                       NOP, NOP, NOP, NOP, 0, 1, 8'h08, 8'h3C, 0));
    vecs.push_back(mkv("r0_write", i_ins(6'h08,0,0,16'd9), i_ins(6'h2B,0,0,16'd3),
                       NOP, NOP, NOP, NOP, 0, 1, 8'h03, 8'h00, 0));
    vecs.push_back(mkv("bad_funct", i_ins(6'h08,0,3,16'd7), i_ins(6'h08,0,1,16'd1),
                       r_ins(1,1,3,6'h21), i_ins(6'h2B,0,3,16'd5), NOP, NOP, 0, 1, 8'h05, 8'h07, 0));
    vecs.push_back(mkv("imm_low8", i_ins(6'h08,0,1,16'h1205), i_ins(6'h2B,0,1,16'h0106),
                       NOP, NOP, NOP, NOP, 0, 1, 8'h06, 8'h05, 0));
    vecs.push_back(mkv("sw_base_wrap", i_ins(6'h08,0,1,16'd250), i_ins(6'h08,0,2,16'h55),
                       i_ins(6'h2B,1,2,16'd10), NOP, NOP, NOP, 0, 1, 8'h04, 8'h55, 0));
    vecs.push_back(mkv("two_sw", i_ins(6'h08,0,1,16'h11), i_ins(6'h2B,0,1,16'h20),
                       i_ins(6'h08,1,1,16'h11), i_ins(6'h2B,0,1,16'h21), NOP, NOP,
                       0, 2, 8'h21, 8'h22, 0));
    vecs.push_back(mkv("illegal_nowrite", i_ins(6'h08,0,2,16'd4), i_ins(6'h3F,0,2,16'd7),
                       i_ins(6'h2B,0,2,16'h0C), NOP, NOP, NOP, 0, 1, 8'h0C, 8'h04, 0));
    vecs.push_back(mkv("beq_taken", NOP, NOP, NOP, NOP, i_ins(6'h04,0,0,16'd2), NOP,
                       1, 0, 8'd7, 8'h00, 5));
    vecs.push_back(mkv("beq_not", i_ins(6'h08,0,1,16'd1), NOP, NOP, NOP,
                       i_ins(6'h04,0,1,16'd2), NOP, 1, 0, 8'd5, 8'h00, 5));
    vecs.push_back(mkv("beq_reg_eq", i_ins(6'h08,0,1,16'd9), i_ins(6'h08,0,2,16'd9),
                       i_ins(6'h04,1,2,16'd3), NOP, NOP, NOP, 1, 0, 8'd6, 8'h00, 3));
    vecs.push_back(mkv("beq_back", i_ins(6'h04,0,0,16'hFFFD), NOP, NOP, NOP, NOP, NOP,
                       1, 0, 8'hFE, 8'h00, 1));
    vecs.push_back(mkv("jump", j_ins(26'h0310), NOP, NOP, NOP, NOP, NOP,
                       1, 0, 8'h10, 8'h00, 1));
    vecs.push_back(mkv("illegal_op", i_ins(6'h3F,1,2,16'd7), NOP, NOP, NOP, NOP, NOP,
                       1, 0, 8'h01, 8'h00, 1));
    vecs.push_back(mkv("pc_wrap", j_ins(26'h00FF), NOP, NOP, NOP, NOP, NOP,
                       1, 0, 8'h00, 8'h00, 2));

    foreach (vecs[v]) begin
      start(vecs[v].prog);
      run_cycles(40);
      check({vecs[v].name, ".overlap"}, ovl, 0);
      if (vecs[v].is_fetch) begin
        check({vecs[v].name, ".fetch_addr"}, fetch_addr[vecs[v].fidx], vecs[v].exp_addr);
        check({vecs[v].name, ".no_strobes"}, wr_cnt + rdm_cnt, 0);
      end else begin
        check({vecs[v].name, ".wr_count"}, wr_cnt, vecs[v].nsw);
        check({vecs[v].name, ".wr_addr"}, last_wa, vecs[v].exp_addr);
        check({vecs[v].name, ".wr_data"}, last_wd, vecs[v].exp_data);
      end
    end

    // Reset from a running state: outputs must drop immediately and stay low.
    p = '0;
    @(negedge clk);
    reset = 1'b0;
    load_prog(p);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst.rden", rden, 0);
      check("rst.address", address, 0);
      check("rst.strobes", {rden_dm, wren_dm}, 0);
      check("rst.dm_outs", {rdaddress_dm, wraddress_dm, write_data_dm}, 0);
      @(negedge clk);
    end
    reset = 1'b1;
    run_cycles(8);
    check("rel.fetch_cnt", fetch_cnt, 3);
    check("rel.first_addr", fetch_addr[0], 0);
    check("rel.first_cyc", fetch_cyc[0], 0);
    check("rel.second_addr", fetch_addr[1], 1);
    check("rel.second_cyc", fetch_cyc[1], 3);
    check("rel.no_strobes", wr_cnt + rdm_cnt, 0);

    // lw occupies four cycles, with the read strobe in EXEC.
    p = '0;
    p[0] = i_ins(6'h23, 0, 5, 16'd7);
    start(p);
    run_cycles(10);
    check("lw.rd_count", rdm_cnt, 1);
    check("lw.rd_cycle", rdm_cyc, 2);
    check("lw.rd_addr", last_ra, 7);
    check("lw.next_fetch_cyc", fetch_cyc[1], 4);
    check("lw.next_fetch_addr", fetch_addr[1], 1);
    check("lw.no_write", wr_cnt, 0);

    // Illegal opcode still takes exactly three cycles.
    p = '0;
    p[0] = i_ins(6'h3F, 0, 0, 16'hFFFF);
    start(p);
    run_cycles(8);
    check("ill.next_fetch_cyc", fetch_cyc[1], 3);
    check("ill.next_fetch_addr", fetch_addr[1], 1);

    // Abort a sw in its EXEC cycle with reset.
    p = '0;
    p[0] = i_ins(6'h08, 0, 1, 16'd9);
    p[1] = i_ins(6'h2B, 0, 1, 16'd0);
    start(p);
    run_cycles(5);
    #1;
    check("abort.pre_wren", wren_dm, 1);
    check("abort.pre_wdata", write_data_dm, 9);
    reset = 1'b0;
    #1;
    check("abort.wren", wren_dm, 0);
    check("abort.wdata", write_data_dm, 0);
    check("abort.address", address, 0);
    check("abort.rden", rden, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_cycles(10);
    check("abort.restart_addr", fetch_addr[0], 0);
    check("abort.restart_wr", wr_cnt, 1);
    check("abort.restart_wdata", last_wd, 9);

    // Registers are cleared by reset: r1 reads back as zero.
    p = '0;
    p[0] = i_ins(6'h2B, 0, 1, 16'd0);
    start(p);
    run_cycles(6);
    check("rfrst.wr_count", wr_cnt, 1);
    check("rfrst.wdata", last_wd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips8_cpu_core.md
Name: mips8_cpu_core

Overview:
- Multicycle MIPS-style processor with 32-bit instructions, an 8-bit datapath and 8-bit word addresses.
- Fetches from an external synchronous instruction RAM and accesses an external synchronous data RAM; both RAMs return read data one cycle after a registered read request.
- Sits between the instruction memory and the data memory in the top-level SoC.

Parameters:
- RF_DEPTH, 32, number of 8-bit general registers (5-bit indices); r0 reads 0, writes to it are ignored.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rden  output  1  instruction-memory read enable.
- address  output  8  instruction-memory read address (= PC).
- command  input  32  instruction-memory read data, valid the cycle after rden.
- rden_dm  output  1  data-memory read enable.
- rdaddress_dm  output  8  data-memory read address.
- read_data_dm  input  8  data-memory read data, valid the cycle after rden_dm.
- wren_dm  output  1  data-memory write strobe.
- wraddress_dm  output  8  data-memory write address.
- write_data_dm  output  8  data-memory write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=0, all registers=0, IR=0, state=FETCH.
  - Outputs rden, rden_dm and wren_dm are 0.
  - All address and data outputs are 0.
- Outputs are decoded from the state register and datapath registers only (Moore style, no combinational path from command or read_data_dm).
- FSM states: FETCH, DECODE, EXEC, MEM.
  - FETCH: rden=1, address=PC; next state DECODE.
  - DECODE: latch command into IR; read rs/rt; PC<=PC+1 (mod 256); next state EXEC.
  - EXEC: execute per opcode (see list); lw goes to MEM, every other opcode goes to FETCH.
  - MEM: rt <= read_data_dm; next state FETCH.
- Instruction fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0].
  - Only imm[7:0] is used; 8-bit arithmetic wraps mod 256.
- Opcodes:
  - R-type (op 0x00): rd <= rs OP rt. funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed 8-bit compare, result 1 or 0). Any other funct is a NOP.
  - addi (op 0x08): rt <= rs + imm[7:0].
  - lw (op 0x23): in EXEC, rden_dm=1 and rdaddress_dm=rs+imm[7:0]; in MEM, rt <= read_data_dm.
  - sw (op 0x2B): in EXEC only, wren_dm=1, wraddress_dm=rs+imm[7:0], write_data_dm=rt.
  - beq (op 0x04): if rs==rt, PC <= PC+imm[7:0]. PC has already been incremented, so the target is old PC+1+offset, wrapping mod 256.
  - j (op 0x02): PC <= instr[7:0].
  - Any other opcode is a NOP and takes 3 cycles.
- Latency:
  - lw takes 4 cycles.
  - All other instructions take 3 cycles.
- Strobe rules:
  - rden_dm and wren_dm are never asserted in the same cycle.
  - Each strobe is asserted for exactly one cycle per instruction.
- Register file:
  - Writes occur on the rising edge at the end of EXEC/MEM.
  - Reads in DECODE see all prior writes.
- Wrap-around: PC 255 -> 0 after increment.
- Reset asserted mid-instruction aborts the instruction immediately. No memory strobe is asserted while reset=0.

Test Plan:
- Reset release: hold reset=0 for 3 cycles, then release.
  - rden=1 with address=0 in the first cycle, address=1 three cycles later.
  - wren_dm=0 and rden_dm=0 throughout.
- addi/add: sequence addi r1,r0,5; addi r2,r0,250; add r3,r1,r2; sw r3,0(r0).
  - wren_dm pulse with wraddress_dm=0 and write_data_dm=255.
- Wrap and slt:
  - addi r1,r0,200; addi r2,r1,100; sw r2,1(r0) -> write_data_dm=44.
  - slt r4,r1,r0 -> 1 (200 is -56); sw r4,2(r0) -> write_data_dm=1.
- lw: lw r5,7(r0) with read_data_dm=0x3C returned the cycle after rden_dm.
  - rdaddress_dm=7 during EXEC.
  - Following sw r5,8(r0) writes 0x3C to address 8.
- beq/j:
  - beq r0,r0,+2 at PC=4 -> next fetch address=7.
  - beq with unequal registers -> next fetch address=5.
  - j 0x10 -> next fetch address=16.
- r0 and illegal opcode:
  - addi r0,r0,9 then sw r0,3(r0) -> write_data_dm=0.
  - op=0x3F -> no strobes; PC advances by 1 in 3 cycles.
